// File: rtl/anita3_readout_pkg.sv
// ---------------------------------------------------------------------------
// anita3_readout_pkg
// Shared definitions for the TURF scaler readout sequencer and related
// arbiters. It holds the frame FSM state encoding, the default word width and
// channel count, the header channel code, the overrun counter width, and the
// saturating-increment helper used by the overrun counter.
// ---------------------------------------------------------------------------
package anita3_readout_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_HDR   = 2'd2,
    ST_SEND  = 2'd3
  } rd_state_t;

  // Default scaler and header word width, and default channel count.
  localparam int WIDTH_DEFAULT = 16;
  localparam int NCH_DEFAULT   = 8;

  // Channel index reported alongside the header word.
  localparam int HDR_CH = 0;

  // Dropped-PPS counter width and its saturation value.
  localparam int                   OVR_CNT_W   = 8;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = '1;

  // The counter stops at all-ones and does not wrap.
  function automatic logic [OVR_CNT_W-1:0] ovr_sat_inc(input logic [OVR_CNT_W-1:0] v);
    logic [OVR_CNT_W-1:0] r;
    if (v == OVR_CNT_MAX) r = v;
    else                  r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/anita3_priority_pick.sv
// ---------------------------------------------------------------------------
// anita3_priority_pick
// Combinational lowest-set-bit finder. It is shared by the scaler readout
// sequencer and other TURF arbiters.
//
// Ports
//   req       in  N    request vector
//   idx       out IW   index of the lowest set bit (0 when req == 0)
//   found     out 1    at least one bit of req is set
//   only_one  out 1    exactly one bit of req is set
// ---------------------------------------------------------------------------
module anita3_priority_pick
  import anita3_readout_pkg::*;
#(
  parameter int N  = NCH_DEFAULT,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          only_one
);

  logic [N-1:0] req_minus_one;

  // The scan runs from the top down, so the lowest set bit is the last one
  // written and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign req_minus_one = req - 1'b1;
  assign found         = |req;
  assign only_one      = found && ((req & req_minus_one) == '0);

endmodule

// File: rtl/anita3_scaler_readout_sequencer.sv
// ---------------------------------------------------------------------------
// anita3_scaler_readout_sequencer
// Per-second readout controller for the TURF scaler bank, in the 33 MHz
// domain. On each PPS rising edge it issues one latch strobe, snapshots every
// scaler channel and the enable mask, and then streams a header word (the PPS
// count) followed by each enabled channel over a valid/ready interface.
// A PPS edge that arrives while a frame is in flight is dropped. The edge is
// still counted in the PPS counter, so the missing frame shows up as a gap in
// the header sequence, and it is also recorded in the overrun flag and the
// overrun counter.
//
// Ports
//   clk33_i        in  1          33 MHz system clock
//   rst_i          in  1          asynchronous active-high reset
//   pps_clk33_i    in  1          PPS, already synchronous to clk33_i
//   scaler_i       in  NCH*WIDTH  packed scalers, channel k at [k*WIDTH +: WIDTH]
//   enable_mask_i  in  NCH        channels to transmit, sampled at latch
//   latch_o        out 1          one-cycle snapshot strobe
//   dat_o          out WIDTH      header (PPS count) or scaler word
//   ch_o           out CHW        channel of the current word (0 on header)
//   hdr_o          out 1          current word is the header
//   last_o         out 1          current word ends the frame
//   valid_o        out 1          word valid
//   ready_i        in  1          downstream accepts the word
//   busy_o         out 1          frame in progress
//   overrun_o      out 1          sticky: a PPS edge was dropped
//   overrun_cnt_o  out 8          saturating count of dropped PPS edges
// ---------------------------------------------------------------------------
module anita3_scaler_readout_sequencer
  import anita3_readout_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CHW   = $clog2(NCH)
) (
  input  logic                 clk33_i,
  input  logic                 rst_i,
  input  logic                 pps_clk33_i,
  input  logic [NCH*WIDTH-1:0] scaler_i,
  input  logic [NCH-1:0]       enable_mask_i,
  output logic                 latch_o,
  output logic [WIDTH-1:0]     dat_o,
  output logic [CHW-1:0]       ch_o,
  output logic                 hdr_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [OVR_CNT_W-1:0] overrun_cnt_o
);

  rd_state_t state_reg, state_next;

  logic                 pps_prev_reg;
  logic                 pps_edge;
  logic [WIDTH-1:0]     pps_cnt_reg;
  logic [WIDTH-1:0]     hdr_word_reg;
  logic [NCH-1:0]       pending_reg;
  logic [NCH-1:0]       pending_next;
  logic [NCH-1:0]       pending_lsb;
  logic [NCH*WIDTH-1:0] shadow_flat_reg;
  logic [WIDTH-1:0]     shadow_word [NCH];
  logic                 overrun_reg;
  logic [OVR_CNT_W-1:0] overrun_cnt_reg;

  logic [CHW-1:0]       pick_idx;
  logic                 pick_found;
  logic                 pick_only_one;
  logic                 handshake;

  assign pps_edge = pps_clk33_i & ~pps_prev_reg;

  // Per-channel view of the shadow bank, used for the word select below.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_shadow_view
    assign shadow_word[gi] = shadow_flat_reg[gi*WIDTH +: WIDTH];
  end

  // Next channel to send is the lowest pending bit.
  anita3_priority_pick #(
    .N  (NCH),
    .IW (CHW)
  ) u_pick (
    .req      (pending_reg),
    .idx      (pick_idx),
    .found    (pick_found),
    .only_one (pick_only_one)
  );

  // Isolate the lowest set bit so it can be cleared on handshake.
  assign pending_lsb = pending_reg & (~pending_reg + 1'b1);

  // ---------------- FSM next-state and outputs ----------------
  always_comb begin
    state_next = state_reg;
    latch_o    = 1'b0;
    valid_o    = 1'b0;
    hdr_o      = 1'b0;
    last_o     = 1'b0;
    dat_o      = '0;
    ch_o       = '0;

    case (state_reg)
      ST_IDLE: begin
        if (pps_edge) state_next = ST_LATCH;
      end

      ST_LATCH: begin
        latch_o    = 1'b1;
        state_next = ST_HDR;
      end

      ST_HDR: begin
        // The header is captured at latch time. A dropped PPS edge that
        // advances the live counter while this word is stalled therefore
        // cannot change it.
        valid_o = 1'b1;
        hdr_o   = 1'b1;
        dat_o   = hdr_word_reg;
        ch_o    = CHW'(HDR_CH);
        last_o  = (pending_reg == '0);
        if (ready_i) state_next = (pending_reg == '0) ? ST_IDLE : ST_SEND;
      end

      ST_SEND: begin
        // The pending mask changes only on handshake, so the presented word
        // holds through any stall.
        valid_o = pick_found;
        dat_o   = shadow_word[pick_idx];
        ch_o    = pick_idx;
        last_o  = pick_only_one;
        if (!pick_found || (ready_i && pick_only_one)) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign handshake = valid_o & ready_i;
  assign busy_o    = (state_reg != ST_IDLE);

  always_comb begin
    pending_next = pending_reg;
    if (state_reg == ST_LATCH)
      pending_next = enable_mask_i;
    else if (state_reg == ST_SEND && handshake)
      pending_next = pending_reg & ~pending_lsb;
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      pps_prev_reg    <= 1'b0;
      pps_cnt_reg     <= '0;
      hdr_word_reg    <= '0;
      pending_reg     <= '0;
      shadow_flat_reg <= '0;
      overrun_reg     <= 1'b0;
      overrun_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pps_prev_reg <= pps_clk33_i;
      pending_reg  <= pending_next;

      // Every edge is counted, including dropped ones.
      if (pps_edge) pps_cnt_reg <= pps_cnt_reg + 1'b1;

      if (state_reg == ST_LATCH) begin
        shadow_flat_reg <= scaler_i;
        hdr_word_reg    <= pps_cnt_reg;
      end

      if (pps_edge && state_reg != ST_IDLE) begin
        overrun_reg     <= 1'b1;
        overrun_cnt_reg <= ovr_sat_inc(overrun_cnt_reg);
      end
    end
  end

  assign overrun_o     = overrun_reg;
  assign overrun_cnt_o = overrun_cnt_reg;

endmodule

// File: tb/tb_anita3_scaler_readout_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for anita3_scaler_readout_sequencer. A frame-level model keeps the
// queue of words each frame must produce and is checked every cycle. Literal
// expectations pin headers, data, timing and overrun behaviour. A second,
// narrow instance (WIDTH=8) exercises PPS counter wrap in few cycles.
// ---------------------------------------------------------------------------
module tb_anita3_scaler_readout_sequencer;

  localparam int NCH   = 8;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  always #15 clk = ~clk;

  logic                 rst, pps, ready;
  logic [NCH*WIDTH-1:0] scaler;
  logic [NCH-1:0]       mask;
  logic                 latch, hdr, last, valid, busy, ovr;
  logic [WIDTH-1:0]     dat;
  logic [2:0]           ch;
  logic [7:0]           ovr_cnt;

  anita3_scaler_readout_sequencer #(.NCH(NCH), .WIDTH(WIDTH)) u_dut (
    .clk33_i(clk), .rst_i(rst), .pps_clk33_i(pps), .scaler_i(scaler),
    .enable_mask_i(mask), .latch_o(latch), .dat_o(dat), .ch_o(ch),
    .hdr_o(hdr), .last_o(last), .valid_o(valid), .ready_i(ready),
    .busy_o(busy), .overrun_o(ovr), .overrun_cnt_o(ovr_cnt)
  );

  // Narrow instance for counter wrap.
  logic        pps2, ready2, latch2, hdr2, last2, valid2, busy2, ovr2;
  logic [15:0] scaler2;
  logic [1:0]  mask2;
  logic [7:0]  dat2, ovr_cnt2;
  logic [0:0]  ch2;

  anita3_scaler_readout_sequencer #(.NCH(2), .WIDTH(8)) u_dut_w8 (
    .clk33_i(clk), .rst_i(rst), .pps_clk33_i(pps2), .scaler_i(scaler2),
    .enable_mask_i(mask2), .latch_o(latch2), .dat_o(dat2), .ch_o(ch2),
    .hdr_o(hdr2), .last_o(last2), .valid_o(valid2), .ready_i(ready2),
    .busy_o(busy2), .overrun_o(ovr2), .overrun_cnt_o(ovr_cnt2)
  );

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
    logic        h;
  } word_t;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
    logic        h;
    logic        l;
    int          cy;
  } logw_t;

  // Model state.
  word_t       m_q[$];
  logic        m_prev;
  logic [15:0] m_cnt;
  bit          m_latch;
  bit          m_ovr;
  int          m_ovr_cnt;

  logw_t log_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  logic  s_busy, s_latch, s_ovr;
  logic [7:0] s_ovr_cnt;
  logic [7:0] h2_prev, h2_cur;
  int    h2_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle. The DUT is compared against the model at the falling
  // edge, and the model then advances with the inputs that the next rising
  // edge will sample.
  task automatic tick();
    bit exp_busy;
    @(negedge clk);
    cyc++;
    s_busy = busy; s_latch = latch; s_ovr = ovr; s_ovr_cnt = ovr_cnt;
    if (rst) begin
      chk("rst_valid", valid, 0);   chk("rst_latch", latch, 0);
      chk("rst_busy", busy, 0);     chk("rst_ovr", ovr, 0);
      chk("rst_ovr_cnt", ovr_cnt, 0); chk("rst_dat", dat, 0);
      chk("rst_ch", ch, 0);         chk("rst_hdr", hdr, 0);
      chk("rst_last", last, 0);
      m_q.delete(); m_prev = 1'b0; m_cnt = '0; m_latch = 0; m_ovr = 0; m_ovr_cnt = 0;
    end else begin
      exp_busy = m_latch || (m_q.size() > 0);
      chk("latch", latch, m_latch);
      chk("valid", valid, m_q.size() > 0);
      chk("busy", busy, exp_busy);
      chk("overrun", ovr, m_ovr);
      chk("overrun_cnt", ovr_cnt, m_ovr_cnt);
      if (m_q.size() > 0) begin
        chk("dat", dat, m_q[0].d);
        chk("ch", ch, m_q[0].c);
        chk("hdr", hdr, m_q[0].h);
        chk("last", last, m_q.size() == 1);
      end
      if (valid && ready) log_q.push_back('{dat, ch, hdr, last, cyc});
      if (m_q.size() > 0 && ready) void'(m_q.pop_front());
      if (m_latch) begin
        m_q.push_back('{m_cnt, 3'd0, 1'b1});
        for (int k = 0; k < NCH; k++)
          if (mask[k]) m_q.push_back('{scaler[k*WIDTH +: WIDTH], 3'(k), 1'b0});
        m_latch = 0;
      end
      if (pps && !m_prev) begin
        m_cnt = m_cnt + 16'd1;
        if (!exp_busy) m_latch = 1;
        else begin
          m_ovr = 1;
          if (m_ovr_cnt < 255) m_ovr_cnt++;
        end
      end
      m_prev = pps;
    end
    if (valid2 && ready2 && hdr2) begin
      h2_prev = h2_cur; h2_cur = dat2; h2_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (!s_busy) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_idle cyc=%0d actual=busy required=idle", cyc);
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NCH; k++) scaler[k*WIDTH +: WIDTH] = 16'(k * 16'h111);
  endtask

  task automatic pps_frame_start(output int t);
    pps = 1'b1; tick(); t = cyc; tick(); pps = 1'b0;
  endtask

  int t, at;

  initial begin
    rst = 1'b1; pps = 1'b0; ready = 1'b1; mask = '0; scaler = '0;
    pps2 = 1'b0; ready2 = 1'b1; mask2 = '0; scaler2 = 16'hA55A;
    h2_prev = '0; h2_cur = '0;
    m_q.delete(); m_prev = 0; m_cnt = 0; m_latch = 0; m_ovr = 0; m_ovr_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // All eight channels with ready held high.
    set_ramp(); mask = 8'hFF; ready = 1'b1; log_q.delete();
    pps_frame_start(t);
    chk("t1_latch_t1", s_latch, 1);
    wait_idle(40, at);
    chk("t1_idle_cycle", at, t + 11);
    chk("t1_words", log_q.size(), 9);
    if (log_q.size() == 9) begin
      chk("t1_hdr_val", log_q[0].d, 16'h0001);
      chk("t1_hdr_flag", log_q[0].h, 1);
      chk("t1_hdr_cyc", log_q[0].cy, t + 2);
      for (int i = 1; i < 9; i++) begin
        chk("t1_data", log_q[i].d, 32'((i - 1) * 32'h111));
        chk("t1_ch", log_q[i].c, i - 1);
      end
      chk("t1_last_ch7", log_q[8].l, 1);
      chk("t1_ch7_cyc", log_q[8].cy, t + 10);
    end

    // Empty mask: only the header is sent.
    mask = 8'h00; log_q.delete();
    pps_frame_start(t);
    wait_idle(20, at);
    chk("t2_idle_cycle", at, t + 3);
    chk("t2_words", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t2_hdr_val", log_q[0].d, 16'h0002);
      chk("t2_hdr_flag", log_q[0].h, 1);
      chk("t2_last", log_q[0].l, 1);
    end

    // Sparse mask, ready toggling, scalers changed after latch.
    for (int k = 0; k < NCH; k++) scaler[k*WIDTH +: WIDTH] = 16'(16'h0100 + k);
    mask = 8'h81; log_q.delete();
    pps_frame_start(t);
    for (int k = 0; k < NCH; k++) scaler[k*WIDTH +: WIDTH] = 16'hF0F0;
    mask = 8'h7E;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      ready = (i % 2 == 1);
      tick();
      if (!s_busy) begin at = cyc; break; end
    end
    chk("t3_done", at, t + 8);
    ready = 1'b1;
    chk("t3_words", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t3_hdr_val", log_q[0].d, 16'h0003);
      chk("t3_ch0_val", log_q[1].d, 16'h0100);
      chk("t3_ch0_ch", log_q[1].c, 0);
      chk("t3_ch7_val", log_q[2].d, 16'h0107);
      chk("t3_ch7_ch", log_q[2].c, 7);
      chk("t3_ch7_last", log_q[2].l, 1);
      chk("t3_ch7_cyc", log_q[2].cy, t + 7);
    end

    // PPS edge while stalled in SEND.
    set_ramp(); mask = 8'hFF; log_q.delete();
    pps_frame_start(t);
    tick(); tick();
    ready = 1'b0;
    tick(); tick();
    pps = 1'b1; tick(); pps = 1'b0; tick();
    chk("t4_overrun", s_ovr, 1);
    chk("t4_overrun_cnt", s_ovr_cnt, 8'd1);
    ready = 1'b1;
    wait_idle(40, at);
    chk("t4_words", log_q.size(), 9);
    if (log_q.size() > 0) chk("t4_hdr_val", log_q[0].d, 16'h0004);
    log_q.delete();
    pps_frame_start(t);
    wait_idle(40, at);
    if (log_q.size() > 0) chk("t4_next_hdr", log_q[0].d, 16'h0006);

    // 300 dropped edges saturate the overrun counter.
    log_q.delete(); ready = 1'b0;
    pps_frame_start(t);
    tick();
    for (int i = 0; i < 300; i++) begin
      pps = 1'b1; tick(); pps = 1'b0; tick();
    end
    chk("t4_sat_cnt", s_ovr_cnt, 8'd255);
    ready = 1'b1;
    wait_idle(40, at);
    chk("t4_sat_words", log_q.size(), 9);
    if (log_q.size() > 0) chk("t4_sat_hdr", log_q[0].d, 16'h0007);

    // Reset in the middle of SEND.
    log_q.delete();
    pps_frame_start(t);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("t5_valid", valid, 0); chk("t5_busy", busy, 0);
    chk("t5_dat", dat, 0);     chk("t5_ch", ch, 0);
    chk("t5_hdr", hdr, 0);     chk("t5_last", last, 0);
    chk("t5_latch", latch, 0); chk("t5_ovr", ovr, 0);
    chk("t5_ovr_cnt", ovr_cnt, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    log_q.delete();
    pps_frame_start(t);
    wait_idle(40, at);
    chk("t5_words", log_q.size(), 9);
    if (log_q.size() == 9) begin
      chk("t5_hdr_val", log_q[0].d, 16'h0001);
      chk("t5_ch7_val", log_q[8].d, 16'h0777);
    end

    // Header wrap on the 8-bit instance: 255 edges, then one more frame.
    for (int e = 0; e < 255; e++) begin
      pps2 = 1'b1; tick(); pps2 = 1'b0; tick();
    end
    repeat (4) tick();
    pps2 = 1'b1; tick(); pps2 = 1'b0;
    repeat (5) tick();
    chk("t6_prewrap_hdr", h2_prev, 8'hFF);
    chk("t6_wrap_hdr", h2_cur, 8'h00);
    chk("t6_frames", h2_n, 129);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
